// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-entry holding buffer and per-frame config.
// The serial line advances one bit per en tick; config is latched with each word.
module uart_tx_param #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    input  logic [3:0]        cfgBits,
    input  logic [1:0]        cfgParity,
    input  logic              cfgStop,
    output logic              out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic              buf_full_q, buf_full_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [3:0]        buf_bits_q, buf_bits_d;
    logic [1:0]        buf_par_q, buf_par_d;
    logic              buf_stop_q, buf_stop_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              out_q, out_d;
    logic              done_q, done_d;

    logic [3:0]        bits_clamped;
    logic [DATA_W-1:0] par_mask;
    logic              buf_par_bit;
    logic              capture;
    logic              last_stop;
    logic              load;

    always_comb begin
        if (cfgBits < 4'd5) begin
            bits_clamped = 4'd5;
        end else if (32'(cfgBits) > DATA_W) begin
            bits_clamped = 4'(DATA_W);
        end else begin
            bits_clamped = cfgBits;
        end
    end

    // Mask wraps to all-ones when buf_bits_q == DATA_W.
    assign par_mask    = (DATA_W'(1) << buf_bits_q) - DATA_W'(1);
    assign buf_par_bit = (^(buf_data_q & par_mask)) ^ (buf_par_q == 2'b10);

    assign capture   = valid && !buf_full_q;
    assign last_stop = (state_q == StStop) && (cnt_q == 4'd1);
    assign load      = en && buf_full_q && ((state_q == StIdle) || last_stop);

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q    <= StIdle;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            buf_bits_q <= 4'd0;
            buf_par_q  <= 2'b00;
            buf_stop_q <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= 4'd0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            out_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            buf_bits_q <= buf_bits_d;
            buf_par_q  <= buf_par_d;
            buf_stop_q <= buf_stop_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            out_q      <= out_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                StIdle:   if (buf_full_q) state_d = StStart;
                StStart:  state_d = StData;
                StData:   if (cnt_q == 4'd1) state_d = par_en_q ? StParity : StStop;
                StParity: state_d = StStop;
                StStop:   if (cnt_q == 4'd1) state_d = buf_full_q ? StStart : StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        buf_bits_d = buf_bits_q;
        buf_par_d  = buf_par_q;
        buf_stop_d = buf_stop_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        out_d      = out_q;
        done_d     = en && last_stop;

        if (capture) begin
            buf_full_d = 1'b1;
            buf_data_d = data;
            buf_bits_d = bits_clamped;
            buf_par_d  = cfgParity;
            buf_stop_d = cfgStop;
        end

        if (en) begin
            unique case (state_q)
                StData: begin
                    if (cnt_q != 4'd1) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (!par_en_q) begin
                        cnt_d = stop2_q ? 4'd2 : 4'd1;
                    end
                end
                StParity: cnt_d = stop2_q ? 4'd2 : 4'd1;
                StStop:   if (cnt_q != 4'd1) cnt_d = cnt_q - 4'd1;
                default:  ;
            endcase

            // Entering or staying in DATA both emit the current LSB.
            unique case (state_d)
                StStart: out_d = 1'b0;
                StData: begin
                    out_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
                StParity: out_d = par_bit_q;
                default:  out_d = 1'b1;
            endcase
        end

        if (load) begin
            buf_full_d = 1'b0;
            shift_d    = buf_data_q;
            cnt_d      = buf_bits_q;
            par_en_d   = ^buf_par_q;
            par_bit_d  = buf_par_bit;
            stop2_d    = buf_stop_q;
        end
    end

    assign ready = !buf_full_q;
    assign busy  = (state_q != StIdle);
    assign out   = out_q;
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: samples the line once per en tick and
// compares against hand-derived bit sequences.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       nReset;
    logic       en;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [3:0] cfgBits;
    logic [1:0] cfgParity;
    logic       cfgStop;
    logic       out;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_W(8)) dut (
        .clk       (clk),
        .nReset    (nReset),
        .en        (en),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .cfgBits   (cfgBits),
        .cfgParity (cfgParity),
        .cfgStop   (cfgStop),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive en/valid at negedge, sample 1 time unit after posedge.
    task automatic step(input logic e, input logic v);
        @(negedge clk);
        en    = e;
        valid = v;
        @(posedge clk);
        #1;
        if (done) done_cnt++;
    endtask

    // Offer a word while idle-ticking, then scramble the inputs so a leak would show.
    task automatic offer(input logic [7:0] d, input logic [3:0] bits, input logic [1:0] par,
                         input logic stop);
        data      = d;
        cfgBits   = bits;
        cfgParity = par;
        cfgStop   = stop;
        step(1'b0, 1'b1);
        data      = ~d;
        cfgBits   = 4'd6;
        cfgParity = par ^ 2'b11;
        cfgStop   = ~stop;
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic [3:0] bits,
                             input logic [1:0] par, input logic stop, input int n,
                             input logic [31:0] exp, input int period);
        done_cnt = 0;
        offer(d, bits, par, stop);
        check_eq({name, "_ready_cap"}, 32'(ready), 32'd0);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            check_eq($sformatf("%s_bit%0d", name, i), 32'(out), 32'(exp[n-1-i]));
            if (i == 0) check_eq({name, "_ready_start"}, 32'(ready), 32'd1);
            repeat (period - 1) step(1'b0, 1'b0);
        end
        check_eq({name, "_done_early"}, done_cnt, 0);
        check_eq({name, "_busy_mid"}, 32'(busy), 32'd1);
        step(1'b1, 1'b0);
        check_eq({name, "_done"}, done_cnt, 1);
        check_eq({name, "_busy_end"}, 32'(busy), 32'd0);
        check_eq({name, "_out_end"}, 32'(out), 32'd1);
        step(1'b0, 1'b0);
        check_eq({name, "_done_once"}, done_cnt, 1);
    endtask

    logic [31:0] b2b_exp;

    initial begin
        nReset    = 1'b0;
        en        = 1'b0;
        valid     = 1'b0;
        data      = 8'h00;
        cfgBits   = 4'd8;
        cfgParity = 2'b00;
        cfgStop   = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("rst_out", 32'(out), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        nReset = 1'b1;
        step(1'b0, 1'b0);

        run_frame("8n1", 8'hA5, 4'd8, 2'b00, 1'b0, 10, 32'b0101001011, 4);
        run_frame("7e2", 8'h41, 4'd7, 2'b01, 1'b1, 11, 32'b01000001011, 3);
        run_frame("5o1", 8'h1F, 4'd5, 2'b10, 1'b0, 8, 32'b01111101, 2);
        run_frame("clamp3", 8'hFF, 4'd3, 2'b00, 1'b0, 7, 32'b0111111, 1);
        run_frame("clamp15", 8'h80, 4'd15, 2'b11, 1'b0, 10, 32'b0000000011, 1);

        // Back-to-back 0x55 then 0xAA with en held high.
        done_cnt = 0;
        b2b_exp  = 32'b01010101010010101011;
        data      = 8'h55;
        cfgBits   = 4'd8;
        cfgParity = 2'b00;
        cfgStop   = 1'b0;
        step(1'b0, 1'b1);
        data = 8'hAA;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i == 1);
            check_eq($sformatf("b2b_bit%0d", i), 32'(out), 32'(b2b_exp[19-i]));
            if (i == 0) check_eq("b2b_ready_start1", 32'(ready), 32'd1);
            if (i == 1) check_eq("b2b_ready_cap2", 32'(ready), 32'd0);
            if (i == 10) begin
                check_eq("b2b_done1", done_cnt, 1);
                check_eq("b2b_ready_start2", 32'(ready), 32'd1);
                check_eq("b2b_busy_gap", 32'(busy), 32'd1);
            end
        end
        step(1'b1, 1'b0);
        check_eq("b2b_done2", done_cnt, 2);
        check_eq("b2b_busy_end", 32'(busy), 32'd0);

        // Reset during data bit 3 with a second word waiting in the buffer.
        done_cnt = 0;
        offer(8'hA5, 4'd8, 2'b00, 1'b0);
        step(1'b1, 1'b0);
        data = 8'h3C;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_eq("rst_mid_pre_out", 32'(out), 32'd0);
        check_eq("rst_mid_pre_ready", 32'(ready), 32'd0);
        nReset = 1'b0;
        step(1'b1, 1'b0);
        check_eq("rst_mid_out", 32'(out), 32'd1);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_ready", 32'(ready), 32'd1);
        nReset = 1'b1;
        repeat (12) step(1'b1, 1'b0);
        check_eq("rst_mid_after_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_after_out", 32'(out), 32'd1);
        check_eq("rst_mid_no_done", done_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, maximum data bits per frame (legal 5..9).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port nReset, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port en, input, 1, bit-period tick; line state advances only on cycles with en=1.
REQ-005 SHALL have port data, input, DATA_W, word to send, LSB first.
REQ-006 SHALL have port valid, input, 1, data/config offered this cycle.
REQ-007 SHALL have port ready, output, 1, holding buffer empty; transfer when valid&&ready.
REQ-008 SHALL have port cfgBits, input, 4, data bits for the offered word.
REQ-009 SHALL have port cfgParity, input, 2, parity mode: 00 none, 01 even, 10 odd, 11 none.
REQ-010 SHALL have port cfgStop, input, 1, stop bits: 0 one, 1 two.
REQ-011 SHALL have port out, output, 1, registered serial line, idle high.
REQ-012 SHALL have port busy, output, 1, high when state != IDLE.
REQ-013 SHALL have port done, output, 1, one-clk pulse at frame completion.

Function
REQ-014 SHALL hold a one-entry buffer (data plus config); ready = buffer empty.
REQ-015 SHALL capture data, cfgBits, cfgParity and cfgStop on valid&&ready, regardless of en.
REQ-016 SHALL ignore valid while ready=0; upstream holds data.
REQ-017 SHALL clamp cfgBits <5 to 5 and >DATA_W to DATA_W at capture.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL, on en in IDLE with buffer full, enter START, load the shift register and frame config, and empty the buffer (ready=1 next cycle).
REQ-020 SHALL, on en in START, enter DATA with bit counter = clamped cfgBits.
REQ-021 SHALL, on each en in DATA, shift one bit; after the last bit go to PARITY if parity enabled, else STOP.
REQ-022 SHALL, on en in PARITY, go to STOP.
REQ-023 SHALL remain in STOP for 1 or 2 en periods per cfgStop; on the final en, go to START if the buffer is full (back-to-back, no idle gap), else IDLE.
REQ-024 SHALL update out on the same edge as the state change: 1 in IDLE/STOP, 0 in START, shift LSB in DATA, parity bit in PARITY.
REQ-025 SHALL compute parity over the clamped cfgBits low bits only: even mode makes total ones even, odd mode makes it odd.
REQ-026 SHALL pulse done for exactly one clk on the edge leaving the final STOP period.
REQ-027 SHALL leave state, out and counters unchanged on cycles with en=0.
REQ-028 SHALL support en held continuously high, giving one bit per clk.
REQ-029 SHALL apply config per frame; a config change while a frame is in progress SHALL NOT affect that frame.

Reset
REQ-030 SHALL, on clk edge with nReset=0, set state IDLE, out=1, busy=0, done=0, ready=1, empty the buffer and clear counters, including mid-frame; a buffered word is discarded.

Verification
REQ-031 SHALL cover 8N1 0xA5, en every 4 clks -> out per bit period 0,1,0,1,0,0,1,0,1,1; done once; busy low after.
REQ-032 SHALL cover cfgBits=7, even parity, 2 stop, 0x41 -> 0,1,0,0,0,0,0,1,0,1,1.
REQ-033 SHALL cover cfgBits=5, odd parity, 0x1F -> 0,1,1,1,1,1,0,1.
REQ-034 SHALL cover 0x55 then 0xAA, 8N1 with continuous en -> second start bit directly follows the first stop bit; ready reasserts one clk after each START entry.
REQ-035 SHALL cover nReset low during DATA bit 3 -> out=1, busy=0, ready=1 next edge; no done.
REQ-036 SHALL cover cfgBits=3 with 0xFF -> sent as 5 bits 1,1,1,1,1.
